// File: rtl/q_learn_pkg.sv
// Shared types and constants for the Q-learning update pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package q_learn_pkg;

  localparam int STATE_WIDTH  = 6;
  localparam int ACTION_WIDTH = 2;
  localparam int DATA_WIDTH   = 8;
  localparam int SUM_WIDTH    = 24;
  localparam int FRAC_SHIFT   = 8;
  localparam int CNT_WIDTH    = 16;
  localparam int Q_ADDR_WIDTH = STATE_WIDTH + ACTION_WIDTH;

  // Write-back sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CMP   = 2'd2,
    WRITE = 2'd3
  } wb_state_e;

  // Q table is laid out state-major: each state owns a contiguous block of actions.
  function automatic logic [Q_ADDR_WIDTH-1:0] q_addr(
    input logic [STATE_WIDTH-1:0]  state,
    input logic [ACTION_WIDTH-1:0] action
  );
    return {state, action};
  endfunction

endpackage

// File: rtl/q_writeback_stage_sat.sv
// q_saturate: drops FRAC_SHIFT fraction bits and clamps the result to DATA_WIDTH.
// Latency: combinational.
// Backpressure: none.
// Ports: i_sum (fixed-point sum) -> o_data (unsigned clamp), o_sat (clamp applied).
module q_saturate #(
  parameter int SUM_WIDTH  = q_learn_pkg::SUM_WIDTH,
  parameter int DATA_WIDTH = q_learn_pkg::DATA_WIDTH,
  parameter int FRAC_SHIFT = q_learn_pkg::FRAC_SHIFT
) (
  input  logic [SUM_WIDTH-1:0]  i_sum,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sat
);
  import q_learn_pkg::*;

  logic [SUM_WIDTH-1:0] shifted;

  assign shifted = i_sum >> FRAC_SHIFT;
  // Any set bit above the output width means the value does not fit.
  assign o_sat   = |shifted[SUM_WIDTH-1:DATA_WIDTH];
  assign o_data  = o_sat ? {DATA_WIDTH{1'b1}} : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/q_writeback_stage.sv
// q_writeback_stage: writes the saturated Q value and read-modify-writes the per-state Qmax.
// Latency: accept in cycle 0, table writes and o_done in cycle 3, ready again in cycle 4.
// Backpressure: o_ready is high only in IDLE; one update per 4 cycles, no overlap.
// Ports: i_valid/o_ready update handshake with i_state/i_action/i_sum/i_end_state;
//        o_q_* Q table write port; o_qm_addr/o_qm_we/i_qm_data Qmax port (write data = o_q_data);
//        o_done/o_sat/o_episode_done commit pulses; o_update_cnt committed-update count.
module q_writeback_stage #(
  parameter int STATE_WIDTH  = q_learn_pkg::STATE_WIDTH,
  parameter int ACTION_WIDTH = q_learn_pkg::ACTION_WIDTH,
  parameter int DATA_WIDTH   = q_learn_pkg::DATA_WIDTH,
  parameter int SUM_WIDTH    = q_learn_pkg::SUM_WIDTH,
  parameter int FRAC_SHIFT   = q_learn_pkg::FRAC_SHIFT,
  parameter int CNT_WIDTH    = q_learn_pkg::CNT_WIDTH
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic [STATE_WIDTH-1:0]              i_state,
  input  logic [ACTION_WIDTH-1:0]             i_action,
  input  logic [SUM_WIDTH-1:0]                i_sum,
  input  logic [STATE_WIDTH-1:0]              i_end_state,
  output logic [STATE_WIDTH+ACTION_WIDTH-1:0] o_q_addr,
  output logic                                o_q_we,
  output logic [DATA_WIDTH-1:0]               o_q_data,
  output logic [STATE_WIDTH-1:0]              o_qm_addr,
  output logic                                o_qm_we,
  input  logic [DATA_WIDTH-1:0]               i_qm_data,
  output logic                                o_done,
  output logic                                o_sat,
  output logic                                o_episode_done,
  output logic [CNT_WIDTH-1:0]                o_update_cnt
);
  import q_learn_pkg::*;

  wb_state_e               fsm_q, fsm_d;
  logic                    accept;
  logic [STATE_WIDTH-1:0]  state_q, end_q;
  logic [ACTION_WIDTH-1:0] action_q;
  logic [DATA_WIDTH-1:0]   qv_q, sat_data;
  logic                    sat_q, sat_flag;
  logic                    upd_max_q;
  logic [CNT_WIDTH-1:0]    cnt_q;

  q_saturate #(
    .SUM_WIDTH  (SUM_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_sat (
    .i_sum  (i_sum),
    .o_data (sat_data),
    .o_sat  (sat_flag)
  );

  assign accept = (fsm_q == IDLE) && i_valid;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fsm_q <= IDLE;
    else          fsm_q <= fsm_d;
  end

  // Next-state logic: fixed walk through the read-compare-write sequence.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (i_valid) fsm_d = READ;
      READ:    fsm_d = CMP;
      CMP:     fsm_d = WRITE;
      WRITE:   fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Captured update, Qmax comparison and commit counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= '0;
      action_q  <= '0;
      end_q     <= '0;
      qv_q      <= '0;
      sat_q     <= 1'b0;
      upd_max_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        state_q  <= i_state;
        action_q <= i_action;
        end_q    <= i_end_state;
        qv_q     <= sat_data;
        sat_q    <= sat_flag;
      end
      if (fsm_q == CMP) begin
        // Strictly greater: an equal value leaves Qmax untouched.
        upd_max_q <= (qv_q > i_qm_data);
        // Advance on entry to WRITE so the count already includes the
        // update being committed while o_done is high.
        cnt_q     <= cnt_q + 1'b1;
      end
    end
  end

  // Output decode: every strobe comes straight from the state register.
  always_comb begin
    o_ready        = 1'b0;
    o_q_we         = 1'b0;
    o_qm_we        = 1'b0;
    o_done         = 1'b0;
    o_sat          = 1'b0;
    o_episode_done = 1'b0;
    unique case (fsm_q)
      IDLE: o_ready = 1'b1;
      WRITE: begin
        o_q_we         = 1'b1;
        o_qm_we        = upd_max_q;
        o_done         = 1'b1;
        o_sat          = sat_q;
        o_episode_done = (state_q == end_q);
      end
      default: ;
    endcase
  end

  // Addresses and data only change on accept, so they hold between updates.
  assign o_q_addr     = q_addr(state_q, action_q);
  assign o_qm_addr    = state_q;
  assign o_q_data     = qv_q;
  assign o_update_cnt = cnt_q;

endmodule

// File: tb/tb_q_writeback_stage.sv
module tb_q_writeback_stage;

  localparam int CW = 8;  // narrow counter so the wrap is reachable quickly

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       qm_we;
    logic       sat;
    logic       ep;
    logic [7:0] cnt;
    int         acc;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_valid = 1'b0;
  logic [5:0]    i_state = '0;
  logic [1:0]    i_action = '0;
  logic [23:0]   i_sum = '0;
  logic [5:0]    i_end_state = '0;
  logic [7:0]    i_qm_data;
  logic          o_ready, o_q_we, o_qm_we, o_done, o_sat, o_episode_done;
  logic [7:0]    o_q_addr, o_q_data;
  logic [5:0]    o_qm_addr;
  logic [CW-1:0] o_update_cnt;

  q_writeback_stage #(.CNT_WIDTH(CW)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_state        (i_state),
    .i_action       (i_action),
    .i_sum          (i_sum),
    .i_end_state    (i_end_state),
    .o_q_addr       (o_q_addr),
    .o_q_we         (o_q_we),
    .o_q_data       (o_q_data),
    .o_qm_addr      (o_qm_addr),
    .o_qm_we        (o_qm_we),
    .i_qm_data      (i_qm_data),
    .o_done         (o_done),
    .o_sat          (o_sat),
    .o_episode_done (o_episode_done),
    .o_update_cnt   (o_update_cnt)
  );

  always #5 i_clk = ~i_clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Qmax table model: registered read, preloaded while reset is held.
  logic [7:0] qm_mem [64];
  logic [7:0] qm_rd;
  assign i_qm_data = qm_rd;
  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 64; i++) qm_mem[i] <= 8'h00;
      qm_mem[5]  <= 8'h10;
      qm_mem[7]  <= 8'h10;
      qm_mem[63] <= 8'h20;
    end else if (o_qm_we) begin
      qm_mem[o_qm_addr] <= o_q_data;
    end
    qm_rd <= qm_mem[o_qm_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: any commit strobe must match the oldest expected update.
  always @(negedge i_clk) begin
    if (i_rst_n && (o_q_we || o_done || o_qm_we || o_sat || o_episode_done)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got q_we=%0b qm_we=%0b done=%0b, expected no commit",
                 o_q_we, o_qm_we, o_done);
      end else begin
        mon_e = sb.pop_front();
        chk("q_we",       32'(o_q_we),         32'd1);
        chk("done",       32'(o_done),         32'd1);
        chk("latency",    32'(cyc - mon_e.acc), 32'd3);
        chk("q_addr",     32'(o_q_addr),       32'(mon_e.addr));
        chk("q_data",     32'(o_q_data),       32'(mon_e.data));
        chk("qm_addr",    32'(o_qm_addr),      32'(mon_e.addr[7:2]));
        chk("qm_we",      32'(o_qm_we),        32'(mon_e.qm_we));
        chk("sat",        32'(o_sat),          32'(mon_e.sat));
        chk("episode",    32'(o_episode_done), 32'(mon_e.ep));
        chk("update_cnt", 32'(o_update_cnt),   32'(mon_e.cnt));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [5:0] s, input logic [1:0] a, input logic [23:0] sum,
                      input logic [5:0] es, input logic [7:0] d, input logic qmwe,
                      input logic sat, input logic ep, input logic [7:0] cnt,
                      input bit push, output int waited);
    exp_t e;
    i_state = s; i_action = a; i_sum = sum; i_end_state = es; i_valid = 1'b1;
    waited = 0;
    while (!o_ready && waited < 16) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got o_ready=0 for %0d cycles, expected 1", waited);
    end
    e.addr = {s, a}; e.data = d; e.qm_we = qmwe; e.sat = sat; e.ep = ep; e.cnt = cnt;
    e.acc = cyc;
    @(posedge i_clk);
    if (push) sb.push_back(e);
    @(negedge i_clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !o_ready) && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    @(negedge i_clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  int w;

  initial begin
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_ready",   32'(o_ready),      32'd1);
    chk("rst_q_we",    32'(o_q_we),       32'd0);
    chk("rst_qm_we",   32'(o_qm_we),      32'd0);
    chk("rst_done",    32'(o_done),       32'd0);
    chk("rst_cnt",     32'(o_update_cnt), 32'd0);
    chk("rst_q_addr",  32'(o_q_addr),     32'd0);
    chk("rst_q_data",  32'(o_q_data),     32'd0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Directed updates: state, action, sum, end, data, qm_we, sat, episode, count.
    send(6'd5,  2'd2, 24'h001200, 6'd63, 8'h12, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, w);
    i_valid = 1'b0; wait_idle();
    send(6'd7,  2'd0, 24'h001000, 6'd63, 8'h10, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, w);
    i_valid = 1'b0; wait_idle();
    send(6'd9,  2'd3, 24'h0FFFFF, 6'd63, 8'hFF, 1'b1, 1'b1, 1'b0, 8'd3, 1'b1, w);
    i_valid = 1'b0; wait_idle();
    send(6'd63, 2'd0, 24'h000500, 6'd63, 8'h05, 1'b0, 1'b0, 1'b1, 8'd4, 1'b1, w);
    i_valid = 1'b0; wait_idle();
    send(6'd62, 2'd1, 24'h000300, 6'd63, 8'h03, 1'b1, 1'b0, 1'b0, 8'd5, 1'b1, w);
    i_valid = 1'b0; wait_idle();
    send(6'd3,  2'd1, 24'h00FF80, 6'd63, 8'hFF, 1'b1, 1'b0, 1'b0, 8'd6, 1'b1, w);
    i_valid = 1'b0; wait_idle();

    chk("qmax5",  32'(qm_mem[5]),  32'h12);
    chk("qmax7",  32'(qm_mem[7]),  32'h10);
    chk("qmax9",  32'(qm_mem[9]),  32'hFF);
    chk("qmax63", 32'(qm_mem[63]), 32'h20);
    chk("qmax62", 32'(qm_mem[62]), 32'h03);

    // i_valid held high: one accept every 4 cycles; the count wraps past 255.
    for (int k = 0; k < 252; k++) begin
      logic [7:0] c;
      c = 8'(6 + k + 1);
      send(6'd10, 2'd0, 24'h000100, 6'd63, 8'h01, (k == 0), 1'b0, 1'b0, c, 1'b1, w);
      if (k > 0) chk("ready_low_cycles", 32'(w), 32'd3);
    end
    i_valid = 1'b0;
    wait_idle();
    chk("cnt_wrapped", 32'(o_update_cnt), 32'd2);

    // Reset during CMP aborts the update.
    send(6'd20, 2'd1, 24'h005000, 6'd63, 8'h50, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, w);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("abort_ready",  32'(o_ready),      32'd1);
    chk("abort_q_we",   32'(o_q_we),       32'd0);
    chk("abort_qm_we",  32'(o_qm_we),      32'd0);
    chk("abort_cnt",    32'(o_update_cnt), 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (6) @(negedge i_clk);
    chk("post_abort_ready", 32'(o_ready),      32'd1);
    chk("post_abort_cnt",   32'(o_update_cnt), 32'd0);
    chk("post_abort_sb",    32'(sb.size()),    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/q_writeback_stage.md
# q_writeback_stage

Final (write-back) stage of the Q-learning update pipeline. Consumes each finished update from the adder stage: a state, an action and the wide fixed-point sum. It shifts and saturates the sum to the Q-value width and writes it to the Q table. It read-modify-writes the Qmax table so each state's entry holds the largest Q value written for that state. It also counts completed updates and flags when the agent has reached the terminal state.

## Interface
Parameters:
- STATE_WIDTH, 6, state index width (64 states)
- ACTION_WIDTH, 2, action index width (4 actions)
- DATA_WIDTH, 8, Q / Qmax entry width (unsigned)
- SUM_WIDTH, 24, width of incoming sum
- FRAC_SHIFT, 8, right shift applied to sum before saturation
- CNT_WIDTH, 16, update counter width

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  upstream has an update
- o_ready  out  1  stage can accept; high only in IDLE
- i_state  in  STATE_WIDTH  state of the update
- i_action  in  ACTION_WIDTH  action of the update
- i_sum  in  SUM_WIDTH  new Q value, fixed-point
- i_end_state  in  STATE_WIDTH  terminal state, sampled at accept
- o_q_addr  out  STATE_WIDTH+ACTION_WIDTH  Q table address {state,action}
- o_q_we  out  1  Q table write enable
- o_q_data  out  DATA_WIDTH  Q table write data
- o_qm_addr  out  STATE_WIDTH  Qmax table address
- o_qm_we  out  1  Qmax table write enable
- i_qm_data  in  DATA_WIDTH  Qmax table read data; registered, valid one cycle after address
- o_done  out  1  one-cycle pulse: update committed
- o_sat  out  1  one-cycle pulse with o_done if saturation occurred
- o_episode_done  out  1  one-cycle pulse with o_done if state == end state
- o_update_cnt  out  CNT_WIDTH  committed updates, wraps

## Operation
- FSM with states IDLE, READ, CMP, WRITE; all outputs registered or decoded from state registers.
- IDLE:
  - o_ready=1.
  - On i_valid&o_ready, capture state, action and end state.
  - Capture qv = (i_sum>>FRAC_SHIFT) saturated to 2^DATA_WIDTH-1, plus a sat flag.
  - Go to READ.
- READ: o_qm_addr=state, o_qm_we=0; go to CMP.
- CMP: i_qm_data is valid; register upd_max = (qv > i_qm_data), strictly greater, so ties do not write; go to WRITE.
- WRITE:
  - o_q_we=1, o_q_addr={state,action}, o_q_data=qv.
  - o_qm_we=upd_max, o_qm_addr=state, Qmax write data is o_q_data (shared bus).
  - o_done=1, o_sat=sat flag, o_episode_done=(state==end state).
  - o_update_cnt increments, wrapping from all-ones to 0.
  - Next state is IDLE.
- Write enables are low in every state except WRITE.
- Table inputs not being written are don't-care but must be stable; addresses hold their last value.

## Timing
- Accept edge = cycle 0. READ occupies cycle 1, CMP cycle 2, WRITE cycle 3. o_ready returns high in cycle 4.
- Throughput: one update per 4 cycles. No back-to-back accept, so two updates to the same state never hazard on Qmax.
- Reset values:
  - FSM=IDLE, o_ready=1 (combinational from IDLE, so high during reset).
  - o_q_we=0, o_qm_we=0, o_done=0, o_sat=0, o_episode_done=0.
  - o_update_cnt=0; addresses and data=0.
- Reset asserted in READ, CMP or WRITE aborts the update. No write is issued after reset takes effect, and the counter is cleared.
- i_valid deasserted while o_ready=0 is ignored. Inputs are sampled only at accept.

## Structure
- Package q_learn_pkg holds:
  - width constants STATE_WIDTH, ACTION_WIDTH, DATA_WIDTH, SUM_WIDTH, FRAC_SHIFT;
  - the FSM state enum (IDLE, READ, CMP, WRITE);
  - the Q-address concatenation helper.
- One sub-module, q_saturate: combinational shift-and-clamp, SUM_WIDTH in, DATA_WIDTH out plus sat flag. It is reused by the adder stage for debug.
- Table instances live in the pipeline top, not here.

## Test plan
- Reset, then accept state=5, action=2, sum=0x001200 with Qmax[5]=0x10 → cycle 3:
  - o_q_addr=0x16, o_q_data=0x12, o_q_we=1;
  - o_qm_we=1 with data 0x12;
  - o_done=1, o_update_cnt=1.
- sum=0x001000 with Qmax=0x10 (tie) → o_q_we=1, o_qm_we=0.
- sum=0x0FFFFF → o_q_data=0xFF, o_sat=1 with o_done.
- state=63 and i_end_state=63 → o_episode_done pulses once with o_done. state=62 gives no pulse.
- i_valid held high continuously → accepts exactly every 4 cycles. o_ready low for cycles 1–3. After 0xFFFF updates plus one more, o_update_cnt wraps to 0.
- Reset asserted during CMP → no o_q_we or o_qm_we pulse; after release, FSM is IDLE, o_ready=1, o_update_cnt=0.
